bram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single port of the on-chip 32-bit block RAM. It grants one master at a time, round-robin, and holds the grant for the master's whole `cyc` assertion. It routes the request, write data and acknowledge between the granted master and the RAM. A watchdog terminates any strobe the RAM fails to acknowledge with a one-cycle error.

---
 rtl/bram_arbiter.sv | 117 +++++++++++
 tb/tb_bram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin two-master Wishbone arbiter for the shared block-RAM port, with strobe watchdog
module bram_arbiter #(
    parameter int timeout_cycles = 255,
    parameter int tmo_width      = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    localparam logic [tmo_width-1:0] tmo_last = tmo_width'(timeout_cycles - 1);

    state_t               r_state, w_state_nxt;
    logic                 r_last, w_last_nxt;
    logic [tmo_width-1:0] r_tmo, w_tmo_nxt;
    logic                 r_tmo_hit, w_tmo_hit_nxt;
    logic                 w_gnt_chg, w_tmo_cnt;

    // grant state, round-robin pointer and watchdog registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_tmo     <= '0;
            r_tmo_hit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_tmo     <= w_tmo_nxt;
            r_tmo_hit <= w_tmo_hit_nxt;
        end
    end

    // next grant: round-robin on contention from IDLE, direct handover on release, never preempt
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_state_nxt = r_last ? GNT0 : GNT1;
                else if (m0_cyc_i)        w_state_nxt = GNT0;
                else if (m1_cyc_i)        w_state_nxt = GNT1;
            end
            GNT0:    if (!m0_cyc_i) w_state_nxt = m1_cyc_i ? GNT1 : IDLE;
            GNT1:    if (!m1_cyc_i) w_state_nxt = m0_cyc_i ? GNT0 : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_last_nxt = (w_state_nxt == GNT0) ? 1'b0 : (w_state_nxt == GNT1) ? 1'b1 : r_last;
    end

    // slave-side mux driven from the registered grant; a pending timeout suppresses the strobe
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (r_state == GNT0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~r_tmo_hit;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (r_state == GNT1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~r_tmo_hit;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // watchdog: count unacknowledged strobe cycles, restart on ack, idle strobe or grant move
    always_comb begin
        w_gnt_chg     = w_state_nxt != r_state;
        w_tmo_cnt     = s_cyc_o & s_stb_o & ~s_ack_i;
        w_tmo_nxt     = (w_tmo_cnt && !w_gnt_chg) ? r_tmo + 1'b1 : '0;
        w_tmo_hit_nxt = w_tmo_cnt & ~w_gnt_chg & (r_tmo == tmo_last);
    end

    assign gnt_o    = r_state;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & gnt_o[0];
    assign m1_ack_o = s_ack_i & gnt_o[1];
    assign m0_err_o = r_tmo_hit & ~s_ack_i & gnt_o[0];
    assign m1_err_o = r_tmo_hit & ~s_ack_i & gnt_o[1];
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench for bram_arbiter with a behavioural block-RAM model
module tb_bram_arbiter;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        m_cyc, m_stb, m_we, m_ack, m_err;
    logic [1:0][31:0]  m_adr, m_dat, m_rdat;
    logic [1:0][3:0]   m_sel;
    logic              s_cyc, s_stb, s_we, s_ack;
    logic [31:0]       s_adr, s_dat, s_rdat;
    logic [3:0]        s_sel;
    logic [1:0]        gnt;

    int                checks = 0;
    int                errors = 0;
    int                wr_cnt = 0;
    int                sel3_cnt = 0;
    bit                ram_noack = 1'b0;
    logic [31:0]       ram [64];
    logic [31:0]       exp_mem [64];
    logic [67:0]       wq [$];
    logic [31:0]       rq0 [$];
    logic [31:0]       rq1 [$];

    bram_arbiter #(.timeout_cycles(4), .tmo_width(8)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_dat),
        .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    // RAM model: captures a request mid-cycle, acknowledges it one edge later, checks writes against the queue
    initial begin
        logic        c_req, c_we;
        logic [31:0] c_adr, c_dat;
        logic [3:0]  c_sel;
        logic [67:0] exp;
        c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_dat = '0; c_sel = '0;
        s_ack = 1'b0; s_rdat = '0;
        forever begin
            @(posedge clk);
            #1;
            s_ack = c_req;
            if (c_req) begin
                if (c_we) begin
                    for (int b = 0; b < 4; b++) if (c_sel[b]) ram[c_adr[7:2]][8*b +: 8] = c_dat[8*b +: 8];
                    wr_cnt++;
                    if (c_sel == 4'b0011) sel3_cnt++;
                    checks++;
                    if (wq.size() == 0) begin
                        errors++;
                        $display("FAIL ram_write unexpected adr=%h dat=%h sel=%b", c_adr, c_dat, c_sel);
                    end else begin
                        exp = wq.pop_front();
                        if ({c_adr, c_dat, c_sel} !== exp) begin
                            errors++;
                            $display("FAIL ram_write got %h/%h/%b required %h/%h/%b",
                                     c_adr, c_dat, c_sel, exp[67:36], exp[35:4], exp[3:0]);
                        end
                    end
                end else begin
                    s_rdat = ram[c_adr[7:2]];
                end
            end
            #5;
            c_req = s_cyc & s_stb & ~s_ack & ~ram_noack & rst_n;
            c_we  = s_we;
            c_adr = s_adr;
            c_dat = s_dat;
            c_sel = s_sel;
        end
    end

    task automatic start(input int m, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
        m_adr[m] = adr;  m_dat[m] = dat;  m_sel[m] = sel;
        if (we) begin
            wq.push_back({adr, dat, sel});
            for (int b = 0; b < 4; b++) if (sel[b]) exp_mem[adr[7:2]][8*b +: 8] = dat[8*b +: 8];
        end else if (m == 0) rq0.push_back(exp_mem[adr[7:2]]);
        else rq1.push_back(exp_mem[adr[7:2]]);
    endtask

    task automatic finish(input int m, input bit drop);
        bit          got = 1'b0;
        logic [31:0] exp;
        logic [1:0]  gexp = (m == 0) ? 2'b01 : 2'b10;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            #3;
            got = m_ack[m];
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout m%0d ack=0 required 1", m);
        end else begin
            checks++;
            if (gnt !== gexp || s_ack !== 1'b1 || m_ack[1-m] !== 1'b0 || m_err !== 2'b00) begin
                errors++;
                $display("FAIL ack_path m%0d gnt=%b s_ack=%b other_ack=%b err=%b required %b 1 0 00",
                         m, gnt, s_ack, m_ack[1-m], m_err, gexp);
            end
            if (!m_we[m]) begin
                exp = (m == 0) ? rq0.pop_front() : rq1.pop_front();
                checks++;
                if (m_rdat[m] !== exp) begin
                    errors++;
                    $display("FAIL read_data m%0d got %h required %h", m, m_rdat[m], exp);
                end
            end
        end
        m_stb[m] = 1'b0;
        if (drop) begin
            m_cyc[m] = 1'b0;
            m_we[m]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        m_cyc = '0; m_stb = '0; m_we = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 2'b00 || m_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b cyc=%b stb=%b ack=%b err=%b required 00 0 0 00 00",
                     gnt, s_cyc, s_stb, m_ack, m_err);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        checks++;
        if (dut.r_last !== 1'b1 || dut.r_tmo !== 8'd0 || dut.r_tmo_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_state last=%b tmo=%0d hit=%b required 1 0 0",
                     dut.r_last, dut.r_tmo, dut.r_tmo_hit);
        end
    endtask

    task automatic test_single_read();
        @(posedge clk);
        #3;
        start(0, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h10 || s_we !== 1'b0) begin
            errors++;
            $display("FAIL single_grant gnt=%b cyc=%b adr=%h we=%b required 01 1 00000010 0",
                     gnt, s_cyc, s_adr, s_we);
        end
        finish(0, 1'b1);
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(posedge clk);
        #3;
        start(0, 1'b0, 32'h20, 32'h0, 4'hF);
        start(1, 1'b0, 32'h24, 32'h0, 4'hF);
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL rr_first gnt=%b required 01", gnt);
        end
        finish(0, 1'b1);
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b10 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL handover gnt=%b cyc=%b required 10 1", gnt, s_cyc);
        end
        finish(1, 1'b1);
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL release_idle gnt=%b required 00", gnt);
        end
        start(0, 1'b0, 32'h28, 32'h0, 4'hF);
        start(1, 1'b0, 32'h2C, 32'h0, 4'hF);
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL rr_alternate gnt=%b required 01", gnt);
        end
        finish(0, 1'b1);
        finish(1, 1'b1);
    endtask

    task automatic test_lock();
        int w0, s0;
        @(posedge clk);
        #3;
        w0 = wr_cnt;
        s0 = sel3_cnt;
        start(0, 1'b1, 32'h40, 32'd1, 4'b0011);
        @(posedge clk);
        #3;
        start(1, 1'b0, 32'h30, 32'h0, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) start(0, 1'b1, 32'h40 + 32'(4 * (i - 1)), 32'(i), 4'b0011);
            checks++;
            if (gnt !== 2'b01) begin
                errors++;
                $display("FAIL lock_gnt beat%0d gnt=%b required 01", i, gnt);
            end
            finish(0, i == 4);
        end
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL lock_handover gnt=%b required 10", gnt);
        end
        finish(1, 1'b1);
        checks++;
        if (wr_cnt - w0 != 4 || sel3_cnt - s0 != 4 || wq.size() != 0) begin
            errors++;
            $display("FAIL lock_strobes writes=%0d sel0011=%0d pending=%0d required 4 4 0",
                     wr_cnt - w0, sel3_cnt - s0, wq.size());
        end
        @(posedge clk);
        #3;
        start(0, 1'b0, 32'h44, 32'h0, 4'hF);
        finish(0, 1'b1);
    endtask

    task automatic test_watchdog();
        @(posedge clk);
        #3;
        ram_noack = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h60; m_sel[1] = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #3;
            checks++;
            if (i < 5) begin
                if (m_err !== 2'b00 || s_stb !== 1'b1 || m_ack !== 2'b00 || gnt !== 2'b10) begin
                    errors++;
                    $display("FAIL wdog_wait cycle%0d err=%b stb=%b ack=%b gnt=%b required 00 1 00 10",
                             i, m_err, s_stb, m_ack, gnt);
                end
            end else if (m_err !== 2'b10 || s_stb !== 1'b0 || m_ack !== 2'b00) begin
                errors++;
                $display("FAIL wdog_fire err=%b stb=%b ack=%b required 10 0 00", m_err, s_stb, m_ack);
            end
        end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (m_err !== 2'b00) begin
            errors++;
            $display("FAIL wdog_once err=%b required 00", m_err);
        end
        ram_noack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[1] = 32'h50; m_dat[1] = 32'hCAFE0001; m_sel[1] = 4'hF;
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b10 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre gnt=%b cyc=%b stb=%b required 10 1 1", gnt, s_cyc, s_stb);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 2'b00 || m_err !== 2'b00) begin
            errors++;
            $display("FAIL mid_async gnt=%b cyc=%b stb=%b ack=%b err=%b required 00 0 0 00 00",
                     gnt, s_cyc, s_stb, m_ack, m_err);
        end
        m_stb[1] = 1'b0;
        m_we[1]  = 1'b0;
        m_cyc[0] = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL mid_rr gnt=%b required 01", gnt);
        end
        m_cyc = '0;
        @(posedge clk);
        #3;
    endtask

    task automatic test_idle();
        m_cyc = '0; m_stb = 2'b11; m_we = 2'b11;
        m_adr = {32'h0000_00F0, 32'h0000_00F4};
        m_dat = {32'h1234_5678, 32'h9ABC_DEF0};
        m_sel = {4'hF, 4'hA};
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #3;
            checks++;
            if ({s_cyc, s_stb, s_we, s_adr, s_dat, s_sel} !== '0 || gnt !== 2'b00 || dut.r_tmo !== 8'd0) begin
                errors++;
                $display("FAIL idle cycle%0d cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b gnt=%b tmo=%0d required all 0",
                         i, s_cyc, s_stb, s_we, s_adr, s_dat, s_sel, gnt, dut.r_tmo);
            end
        end
        m_stb = '0;
        m_we  = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            exp_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end
        ram[4]     = 32'hDEADBEEF;
        exp_mem[4] = 32'hDEADBEEF;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_lock();
        test_watchdog();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "bench did not complete");
    end
endmodule
